// File: rtl/vga_text_render.sv
// vga_text_render: four-stage text-mode pixel pipeline.
// Turns sync-generator pixel coordinates into palette indices by reading a
// character buffer and a font ROM, both with one-cycle read latency, and
// overlays a blinking underline cursor. Sync and blanking travel a matched
// delay line so that hsync_o/vsync_o line up with color_o.
module vga_text_render #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [9:0]  x_px_i,
    input  logic [9:0]  y_px_i,
    input  logic        activevideo_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    output logic [11:0] char_addr_o,
    input  logic [15:0] char_data_i,
    output logic [11:0] font_addr_o,
    input  logic [7:0]  font_data_i,
    input  logic        cursor_en_i,
    input  logic [6:0]  cursor_col_i,
    input  logic [4:0]  cursor_row_i,
    output logic [3:0]  color_o,
    output logic        hsync_o,
    output logic        vsync_o
);

    localparam int       CNT_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [6:0] COLS_L  = 7'(COLS);
    localparam logic [5:0] ROWS_L  = 6'(ROWS);

    logic [6:0]  col;
    logic [5:0]  row;
    logic [11:0] row_ext;
    logic [11:0] row_offset;
    logic [11:0] next_addr;
    logic        cursor_hit;

    logic [3:0]       hs_pipe;
    logic [3:0]       vs_pipe;
    logic [2:0]       av_pipe;
    logic [1:0][2:0]  x_pipe;
    logic [3:0]       y_d1;
    logic [1:0]       hit_pipe;

    logic [3:0]  fg_s2;
    logic [3:0]  bg_s2;
    logic [3:0]  pixel_s3;
    logic        font_bit;

    logic [CNT_W-1:0] frame_cnt;
    logic             blink_on;
    logic             vs_prev;

    assign col     = x_px_i[9:3];
    assign row     = y_px_i[9:4];
    assign row_ext = {6'b0, row};

    // The common 80-column case uses shifts and an add instead of a multiplier.
    generate
        if (COLS == 80) begin : g_mul80
            assign row_offset = (row_ext << 6) + (row_ext << 4);
        end else begin : g_mulgen
            assign row_offset = 12'(row_ext * 12'(COLS));
        end
    endgenerate

    assign next_addr = row_offset + {5'b0, col};

    // Cursor is an underline on the last two glyph lines; off-screen positions never match.
    assign cursor_hit = cursor_en_i
                     && (col == cursor_col_i)
                     && (row == {1'b0, cursor_row_i})
                     && (y_px_i[3:1] == 3'b111)
                     && (cursor_col_i < COLS_L)
                     && ({1'b0, cursor_row_i} < ROWS_L);

    assign font_bit = font_data_i[~x_pipe[1]];

    // Stage 1: buffer address, held while blanking, plus the delay lines.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            char_addr_o <= '0;
            hs_pipe     <= '1;
            vs_pipe     <= '1;
            av_pipe     <= '0;
            x_pipe      <= '0;
            y_d1        <= '0;
            hit_pipe    <= '0;
        end else begin
            if (activevideo_i) begin
                char_addr_o <= next_addr;
            end
            hs_pipe  <= {hs_pipe[2:0], hsync_i};
            vs_pipe  <= {vs_pipe[2:0], vsync_i};
            av_pipe  <= {av_pipe[1:0], activevideo_i};
            x_pipe   <= {x_pipe[0], x_px_i[2:0]};
            y_d1     <= y_px_i[3:0];
            hit_pipe <= {hit_pipe[0], cursor_hit};
        end
    end

    // Stage 2: font ROM address from the glyph code and capture of the colour pair.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            font_addr_o <= '0;
            fg_s2       <= '0;
            bg_s2       <= '0;
        end else begin
            font_addr_o <= {char_data_i[7:0], y_d1};
            fg_s2       <= char_data_i[11:8];
            bg_s2       <= char_data_i[15:12];
        end
    end

    // Stages 3 and 4: pick fg/bg from the glyph bit or visible cursor, then blank.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pixel_s3 <= '0;
            color_o  <= '0;
        end else begin
            pixel_s3 <= ((hit_pipe[1] && blink_on) || font_bit) ? fg_s2 : bg_s2;
            color_o  <= av_pipe[2] ? pixel_s3 : 4'd0;
        end
    end

    // Frame counter on registered vsync falling edges drives the cursor blink.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
            vs_prev   <= 1'b1;
        end else begin
            vs_prev <= vsync_i;
            if (vs_prev && !vsync_i) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign hsync_o = hs_pipe[3];
    assign vsync_o = vs_pipe[3];

endmodule

// File: tb/tb_vga_text_render.sv
// tb_vga_text_render: drives pixel coordinates cycle by cycle and compares the
// renderer against a cell/glyph model built from plain arithmetic over the
// character and font memories held in the bench.
`timescale 1ns/1ps
module tb_vga_text_render;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [9:0]  x_px_i = '0;
    logic [9:0]  y_px_i = '0;
    logic        activevideo_i = 1'b0;
    logic        hsync_i = 1'b1;
    logic        vsync_i = 1'b1;
    logic [11:0] char_addr_o;
    logic [15:0] char_data_i;
    logic [11:0] font_addr_o;
    logic [7:0]  font_data_i;
    logic        cursor_en_i = 1'b0;
    logic [6:0]  cursor_col_i = '0;
    logic [4:0]  cursor_row_i = '0;
    logic [3:0]  color_o;
    logic        hsync_o;
    logic        vsync_o;

    logic [15:0] cmem [0:4095];
    logic [7:0]  fmem [0:4095];

    int checks = 0;
    int errors = 0;

    logic [5:0]  expQ[$];
    logic [11:0] mCharAddr;
    logic [11:0] mFontAddr;
    logic [3:0]  prevY;
    int          frameCnt;
    logic        blinkOn;
    logic        prevVs;

    vga_text_render dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .x_px_i        (x_px_i),
        .y_px_i        (y_px_i),
        .activevideo_i (activevideo_i),
        .hsync_i       (hsync_i),
        .vsync_i       (vsync_i),
        .char_addr_o   (char_addr_o),
        .char_data_i   (char_data_i),
        .font_addr_o   (font_addr_o),
        .font_data_i   (font_data_i),
        .cursor_en_i   (cursor_en_i),
        .cursor_col_i  (cursor_col_i),
        .cursor_row_i  (cursor_row_i),
        .color_o       (color_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o)
    );

    // Memories with one-cycle latency relative to the registered addresses.
    assign char_data_i = cmem[char_addr_o];
    assign font_data_i = fmem[font_addr_o];

    always #20 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
        end
    endtask

    function automatic logic [3:0] expColor(input int x, input int y, input logic act);
        int          c;
        int          r;
        logic [15:0] w;
        logic [7:0]  g;
        logic        b;
        logic        hit;
        if (!act) return 4'd0;
        c   = x / 8;
        r   = y / 16;
        w   = cmem[12'(r * 80 + c)];
        g   = fmem[{w[7:0], 4'(y % 16)}];
        b   = g[7 - (x % 8)];
        hit = cursor_en_i && (int'(cursor_col_i) == c) && (int'(cursor_row_i) == r) && ((y % 16) >= 14);
        return ((hit && blinkOn) || b) ? w[11:8] : w[15:12];
    endfunction

    task automatic resetModel();
        expQ.delete();
        repeat (4) expQ.push_back(6'b110000);
        mCharAddr = '0;
        mFontAddr = '0;
        prevY     = '0;
        frameCnt  = 0;
        blinkOn   = 1'b1;
        prevVs    = 1'b1;
    endtask

    // Called right after a falling edge: check what the DUT shows now, drive the next pixel.
    task automatic applyStimulus(input int x, input int y, input logic act, input logic hs, input logic vs);
        if (expQ.size() >= 4) begin
            checkOutput("pixel", {10'b0, vsync_o, hsync_o, color_o}, {10'b0, expQ.pop_front()});
        end
        checkOutput("char_addr", {4'b0, char_addr_o}, {4'b0, mCharAddr});
        checkOutput("font_addr", {4'b0, font_addr_o}, {4'b0, mFontAddr});
        x_px_i        = 10'(x);
        y_px_i        = 10'(y);
        activevideo_i = act;
        hsync_i       = hs;
        vsync_i       = vs;
        if (prevVs && !vs) begin
            if (frameCnt == 31) begin
                frameCnt = 0;
                blinkOn  = ~blinkOn;
            end else begin
                frameCnt++;
            end
        end
        prevVs = vs;
        expQ.push_back({vs, hs, expColor(x, y, act)});
        mFontAddr = {cmem[mCharAddr][7:0], prevY};
        if (act) mCharAddr = 12'((y / 16) * 80 + x / 8);
        prevY = 4'(y % 16);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic cursorScan();
        for (int x = 24; x < 32; x++) applyStimulus(x, 46, 1'b1, 1'b1, 1'b1);
        for (int x = 24; x < 32; x++) applyStimulus(x, 45, 1'b1, 1'b1, 1'b1);
        idle(6);
    endtask

    task automatic vsyncPulses(input int n);
        repeat (n) begin
            applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
            applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
            applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
            applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
        end
        idle(6);
    endtask

    initial begin
        int cc;
        int cr;
        int x;
        int y;
        for (int i = 0; i < 4096; i++) begin
            cmem[i] = 16'($urandom);
            fmem[i] = 8'($urandom);
        end
        cmem[0]      = 16'h2141;
        fmem[12'h410] = 8'h80;
        cmem[2399]   = 16'h5307;
        fmem[12'h07F] = 8'hFE;
        cmem[163]    = 16'h3A55;
        fmem[12'h55D] = 8'h00;
        fmem[12'h55E] = 8'h00;
        fmem[12'h55F] = 8'h00;

        repeat (5) @(negedge clk_i);
        rstn_i = 1'b1;
        resetModel();

        // Top-left cell: glyph 0x41 line 0, leftmost bit set -> fg 1.
        applyStimulus(0, 0, 1'b1, 1'b1, 1'b1);
        idle(6);
        // Bottom-right pixel, rightmost bit clear -> bg 5.
        applyStimulus(639, 479, 1'b1, 1'b1, 1'b1);
        idle(6);

        // 96-cycle hsync pulse during blanking.
        for (int i = 0; i < 96; i++) applyStimulus($urandom_range(0, 639), $urandom_range(0, 479), 1'b0, 1'b0, 1'b1);
        idle(8);

        // Random pixels, half of them steered into the current cursor cell.
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                cursor_en_i  = ($urandom % 4) != 0;
                cursor_col_i = 7'($urandom_range(0, 127));
                cursor_row_i = 5'($urandom_range(0, 31));
            end
            cc = int'(cursor_col_i) % 80;
            cr = int'(cursor_row_i) % 30;
            if ($urandom % 2) begin
                x = cc * 8 + $urandom_range(0, 7);
                y = cr * 16 + $urandom_range(12, 15);
            end else begin
                x = $urandom_range(0, 639);
                y = $urandom_range(0, 479);
            end
            applyStimulus(x, y, ($urandom % 4) != 0, 1'($urandom), 1'b1);
        end
        idle(6);

        // Cursor at column 3 row 2 through the blink cycle.
        cursor_en_i  = 1'b1;
        cursor_col_i = 7'd3;
        cursor_row_i = 5'd2;
        cursorScan();
        vsyncPulses(32);
        cursorScan();
        vsyncPulses(32);
        cursorScan();
        vsyncPulses(32);

        // Reset mid-line with the pipeline full of active pixels while the cursor is hidden.
        for (int i = 0; i < 6; i++) applyStimulus(24 + i, 46, 1'b1, 1'b1, 1'b1);
        #2 rstn_i = 1'b0;
        #1;
        checkOutput("rst_color", {12'b0, color_o}, 16'h0);
        checkOutput("rst_char_addr", {4'b0, char_addr_o}, 16'h0);
        checkOutput("rst_font_addr", {4'b0, font_addr_o}, 16'h0);
        checkOutput("rst_hsync", {15'b0, hsync_o}, 16'h1);
        checkOutput("rst_vsync", {15'b0, vsync_o}, 16'h1);
        x_px_i        = '0;
        y_px_i        = '0;
        activevideo_i = 1'b0;
        hsync_i       = 1'b1;
        vsync_i       = 1'b1;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        resetModel();
        cursorScan();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_text_render.md
VGA_TEXT_RENDER -- requirements
Module: vga_text_render

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 30, text rows per frame.
REQ-003 Parameter BLINK_FRAMES, default 32, frames per cursor blink half-period.
REQ-004 clk_i  input  1  pixel clock, 25 MHz; all logic on rising edge.
REQ-005 rstn_i  input  1  asynchronous, active-low reset.
REQ-006 x_px_i  input  10  active-area pixel column, 0..639, from sync generator.
REQ-007 y_px_i  input  10  active-area pixel line, 0..479.
REQ-008 activevideo_i  input  1  1 = pixel inside display area.
REQ-009 hsync_i / vsync_i  input  1 each  active-low sync pulses from sync generator.
REQ-010 char_addr_o  output  12  character buffer read address, row*COLS+col.
REQ-011 char_data_i  input  16  buffer word: [7:0] glyph code, [11:8] fg index, [15:12] bg index; valid 1 cycle after char_addr_o.
REQ-012 font_addr_o  output  12  font ROM address {glyph code, glyph line[3:0]}.
REQ-013 font_data_i  input  8  glyph line bits, bit 7 = leftmost pixel; valid 1 cycle after font_addr_o.
REQ-014 cursor_en_i  input  1  1 = cursor drawn.
REQ-015 cursor_col_i / cursor_row_i  input  7 / 5  cursor cell position.
REQ-016 color_o  output  4  palette index of current pixel.
REQ-017 hsync_o / vsync_o  output  1 each  sync pulses delayed to align with color_o.

Function
REQ-018 Cell size SHALL be fixed 8x16 pixels: col = x_px_i[9:3], row = y_px_i[9:4].
REQ-019 Stage 1 SHALL register char_addr_o = row*COLS + col using shift-add (row<<6 + row<<4 for COLS=80), 12-bit, max 2399.
REQ-020 Stage 2 SHALL register font_addr_o = {char_data_i[7:0], delayed y[3:0]} and capture fg/bg indices.
REQ-021 Stage 3 SHALL select font bit 7 - delayed x[2:0] from font_data_i; pixel = fg if bit 1, else bg.
REQ-022 Stage 4 SHALL register color_o; total latency from x/y/activevideo/sync inputs to color_o SHALL be exactly 4 cycles.
REQ-023 hsync_i, vsync_i, activevideo_i, x[2:0], y[3:0] and cursor-hit flag SHALL travel a 4-deep delay line matched to the data path.
REQ-024 color_o SHALL be 0 whenever the delayed activevideo is 0, regardless of buffer/ROM data.
REQ-025 Cursor hit SHALL be evaluated in stage 1: cursor_en_i=1, col==cursor_col_i, row==cursor_row_i, y[3:0] in {14,15}.
REQ-026 When cursor hit and blink_on=1, stage 3 SHALL output fg index irrespective of font bit.
REQ-027 Frame counter SHALL increment on each vsync_i falling edge (registered edge detect); at BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_on.
REQ-028 Cursor position outside COLS/ROWS SHALL never hit; no error output.
REQ-029 Inputs x/y SHALL be ignored for addressing when activevideo_i=0; char_addr_o holds its last value.
REQ-030 Cursor inputs changing mid-frame SHALL take effect on the next stage-1 sample; no synchronization required (same clock domain).

Reset
REQ-031 On rstn_i low: color_o=0, char_addr_o=0, font_addr_o=0, hsync_o=1, vsync_o=1, all delay-line sync stages=1, activevideo stages=0.
REQ-032 On reset: frame counter=0, blink_on=1, vsync edge register=1.
REQ-033 Reset asserted mid-line SHALL clear the pipeline immediately; first valid color_o SHALL appear 4 cycles after first active input following release.

Verification
REQ-034 x=0,y=0 active, char_data_i=0x2141, font_data_i=0x80 -> char_addr_o=0 at +1, font_addr_o=0x410 at +2, color_o=1 at +4.
REQ-035 x=639,y=479 active, font bit 0 clear, char_data_i=0x5307 -> char_addr_o=2399, color_o=5 (bg) at +4.
REQ-036 hsync_i low pulse of 96 cycles -> hsync_o low pulse of 96 cycles starting exactly 4 cycles later; activevideo_i=0 -> color_o=0 with font_data_i=0xFF.
REQ-037 Cursor at col 3,row 2, enable=1, y=46, x=24..31, font_data_i=0x00, fg=0xA -> color_o=0xA for 8 pixels; y=45 -> bg.
REQ-038 32 vsync falling edges -> blink_on 1->0, cursor pixels show bg/font; 32 more -> cursor visible again.
REQ-039 rstn_i pulsed low mid-line with pipeline full -> all outputs at reset values same cycle; blink_on=1 after release.
